// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states and opcode helpers shared by alu_seq and its benches
package alu_pkg;

  localparam logic [3:0] OP_ADD       = 4'd1;
  localparam logic [3:0] OP_ADD_CARRY = 4'd2;
  localparam logic [3:0] OP_SUB       = 4'd3;
  localparam logic [3:0] OP_INC       = 4'd4;
  localparam logic [3:0] OP_DEC       = 4'd5;
  localparam logic [3:0] OP_AND       = 4'd6;
  localparam logic [3:0] OP_NOT       = 4'd7;
  localparam logic [3:0] OP_ROL1      = 4'd8;
  localparam logic [3:0] OP_ROR1      = 4'd9;
  localparam logic [3:0] OP_MUL       = 4'd10;
  localparam logic [3:0] OP_OR        = 4'd11;
  localparam logic [3:0] OP_XOR       = 4'd12;
  localparam logic [3:0] OP_ROLN      = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // MUL is the only multi-cycle operation; everything else completes in one cycle
  function automatic logic op_is_mul(input logic [3:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative unsigned shift-add multiplier, one partial product per cycle
module alu_mul_iter #(
  parameter int B_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [B_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               done,
  output logic [2*B_W-1:0]   product
);

  localparam int CNT_W = $clog2(B_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(B_W - 1);

  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [B_W-1:0]     mcand_q, mcand_d;
  logic [B_W-1:0]     hi_q, hi_d;
  logic [B_W-1:0]     lo_q, lo_d;
  logic [B_W:0]       sum;

  // Right-shifting accumulator: {hi,lo} starts as {0,b}; each step adds the
  // multiplicand into hi when lo[0] is set, then shifts the pair right by one.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (start) begin
      busy_d  = 1'b1;
      cnt_d   = '0;
      mcand_d = a;
      hi_d    = '0;
      lo_d    = b;
    end else if (busy_q) begin
      hi_d  = sum[B_W:1];
      lo_d  = {sum[0], lo_q[B_W-1:1]};
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LAST_STEP) begin
        busy_d = 1'b0;
      end
    end
  end

  // The final step's result is presented directly so the caller can register
  // it on the same edge that retires the last partial product.
  assign done    = busy_q && (cnt_q == LAST_STEP);
  assign product = {hi_d, lo_d};

  // Iteration state; reset aborts any multiply in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with valid/ready handshake and iterative multiply
module alu_seq
  import alu_pkg::*;
#(
  parameter int B_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [B_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic             c_in,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [B_W-1:0]   y,
  output logic [B_W-1:0]   y_hi,
  output logic             c_out,
  output logic             borrow,
  output logic             invalid_op,
  output logic             zero,
  output logic             parity
);

  localparam int SH_W = $clog2(B_W);

  alu_state_e       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [B_W-1:0]   y_q, y_d;
  logic [B_W-1:0]   y_hi_q, y_hi_d;
  logic             c_out_q, c_out_d;
  logic             borrow_q, borrow_d;
  logic             invalid_q, invalid_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;

  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [2*B_W-1:0] mul_product;

  logic [B_W-1:0]   alu_y;
  logic             alu_c;
  logic             alu_br;
  logic             alu_inv;
  logic [B_W:0]     wide;
  logic [SH_W-1:0]  rot_n;

  logic             load;
  logic [B_W-1:0]   ld_y;
  logic [B_W-1:0]   ld_hi;
  logic             ld_c;
  logic             ld_br;
  logic             ld_inv;

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  alu_mul_iter #(.B_W(B_W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle operations evaluated straight from the inputs at accept time
  always_comb begin
    alu_y   = '0;
    alu_c   = 1'b0;
    alu_br  = 1'b0;
    alu_inv = 1'b0;
    wide    = '0;
    rot_n   = SH_W'(32'(b[SH_W-1:0]) % B_W);
    case (opcode)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        alu_y = wide[B_W-1:0];
      end
      OP_ADD_CARRY: begin
        wide  = {1'b0, a} + {1'b0, b} + {{B_W{1'b0}}, c_in};
        alu_y = wide[B_W-1:0];
        alu_c = wide[B_W];
      end
      OP_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        alu_y  = wide[B_W-1:0];
        alu_br = wide[B_W];
      end
      OP_INC: begin
        wide  = {1'b0, a} + (B_W+1)'(1);
        alu_y = wide[B_W-1:0];
        alu_c = wide[B_W];
      end
      OP_DEC: begin
        wide   = {1'b0, a} - (B_W+1)'(1);
        alu_y  = wide[B_W-1:0];
        alu_br = wide[B_W];
      end
      OP_AND:  alu_y = a & b;
      OP_NOT:  alu_y = ~a;
      OP_ROL1: alu_y = {a[B_W-2:0], a[B_W-1]};
      OP_ROR1: alu_y = {a[0], a[B_W-1:1]};
      OP_MUL:  alu_y = '0;
      OP_OR:   alu_y = a | b;
      OP_XOR:  alu_y = a ^ b;
      // A zero amount shifts the wrap-around term out entirely, leaving y = a
      OP_ROLN: alu_y = (a << rot_n) | (a >> (B_W - int'(rot_n)));
      default: alu_inv = 1'b1;
    endcase
  end

  // Next-state and result-register load selection
  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    load      = 1'b0;
    ld_y      = alu_y;
    ld_hi     = '0;
    ld_c      = alu_c;
    ld_br     = alu_br;
    ld_inv    = alu_inv;
    case (state_q)
      ST_BUSY: begin
        if (mul_done) begin
          load    = 1'b1;
          ld_y    = mul_product[B_W-1:0];
          ld_hi   = mul_product[2*B_W-1:B_W];
          ld_c    = |mul_product[2*B_W-1:B_W];
          ld_br   = 1'b0;
          ld_inv  = 1'b0;
          state_d = ST_DONE;
        end
      end
      default: begin
        if (accept) begin
          if (op_is_mul(opcode)) begin
            mul_start = 1'b1;
            state_d   = ST_BUSY;
          end else begin
            load    = 1'b1;
            state_d = ST_DONE;
          end
        end else if ((state_q == ST_DONE) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase

    // Results and flags only change on a load, so they hold through IDLE/BUSY
    out_valid_d = (state_d == ST_DONE);
    y_d         = load ? ld_y   : y_q;
    y_hi_d      = load ? ld_hi  : y_hi_q;
    c_out_d     = load ? ld_c   : c_out_q;
    borrow_d    = load ? ld_br  : borrow_q;
    invalid_d   = load ? ld_inv : invalid_q;
    zero_d      = load ? (ld_y == '0) : zero_q;
    parity_d    = load ? (^ld_y) : parity_q;
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      y_hi_q      <= '0;
      c_out_q     <= 1'b0;
      borrow_q    <= 1'b0;
      invalid_q   <= 1'b0;
      zero_q      <= 1'b0;
      parity_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      y_hi_q      <= y_hi_d;
      c_out_q     <= c_out_d;
      borrow_q    <= borrow_d;
      invalid_q   <= invalid_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign y          = y_q;
  assign y_hi       = y_hi_q;
  assign c_out      = c_out_q;
  assign borrow     = borrow_q;
  assign invalid_op = invalid_q;
  assign zero       = zero_q;
  assign parity     = parity_q;

endmodule
